// File: rtl/uart_tx_cfg.sv
// UART transmitter for the debug transport: configurable frame format, fractional baud
// generator, one-entry holding register, pause/resume escape frames and TX channel mux.
module uart_tx_cfg #(
    parameter int          CLK_RATE  = 100_000_000,
    parameter int          BAUD_RATE = 115200,
    parameter int          DATA_BITS = 8,
    parameter int          PARITY    = 0,
    parameter int          STOP_BITS = 1,
    parameter int          ESC_EN    = 1,
    parameter logic [7:0]  ESC       = 8'hB1,
    parameter logic [7:0]  RESUME    = 8'h00
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic [DATA_BITS-1:0] DATA_I,
    input  logic                 TX_START_I,
    output logic                 TX_READY_O,
    input  logic                 ESC_DETECTED_I,
    input  logic                 SEND_PAUSE_I,
    input  logic                 CHANNEL_I,
    input  logic                 TX2_I,
    output logic                 TX_O,
    output logic                 TX_BUSY_O,
    output logic                 TX_DONE_O
);

    localparam int               ACC_W     = $clog2(CLK_RATE) + 1;
    localparam logic [ACC_W-1:0] BAUD_INC  = ACC_W'(BAUD_RATE);
    localparam logic [ACC_W-1:0] CLK_MAX   = ACC_W'(CLK_RATE);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    generate
        if (ESC_EN != 0 && DATA_BITS != 8) begin : g_bad_cfg
            $error("uart_tx_cfg: ESC_EN requires DATA_BITS == 8");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    state_t state, state_nxt;

    logic [DATA_BITS-1:0] hold, shreg, frame_byte;
    logic                 hold_esc, hold_valid, pausing, last_esc, par_bit;
    logic                 tx_reg, tx_nxt;
    logic [ACC_W-1:0]     acc, acc_sum;
    logic [3:0]           cnt;
    logic                 tick, final_tick, load_pt, pause_evt, resume_evt;
    logic                 load_ctrl, load_data, load, accept;

    // A load point is IDLE or the final stop tick; escape events are only sampled there.
    always_comb begin
        acc_sum    = acc + BAUD_INC;
        tick       = (state != S_IDLE) && (acc_sum >= CLK_MAX);
        final_tick = (state == S_STOP) && tick && (cnt == LAST_STOP);
        load_pt    = !CHANNEL_I && ((state == S_IDLE) || final_tick);
        pause_evt  = (ESC_EN != 0) && SEND_PAUSE_I && !pausing;
        resume_evt = (ESC_EN != 0) && !SEND_PAUSE_I && pausing;
        load_ctrl  = load_pt && (pause_evt || resume_evt) && !last_esc;
        load_data  = load_pt && !load_ctrl && hold_valid;
        load       = load_ctrl || load_data;
        frame_byte = load_ctrl ? (pause_evt ? DATA_BITS'(ESC) : DATA_BITS'(RESUME)) : hold;
        accept     = TX_START_I && !hold_valid && !CHANNEL_I;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I || CHANNEL_I) state <= S_IDLE;
        else                    state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (load) state_nxt = S_START;
            S_START:  if (tick) state_nxt = S_DATA;
            S_DATA:   if (tick && cnt == LAST_DATA) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (tick) state_nxt = S_STOP;
            S_STOP:   if (final_tick) state_nxt = load ? S_START : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Line level is registered and only changes on bit boundaries.
    always_comb begin
        tx_nxt = tx_reg;
        if (load || tick) begin
            case (state_nxt)
                S_START:  tx_nxt = 1'b0;
                S_DATA:   tx_nxt = shreg[0];
                S_PARITY: tx_nxt = par_bit;
                default:  tx_nxt = 1'b1;
            endcase
        end
        TX_O       = CHANNEL_I ? TX2_I : tx_reg;
        TX_READY_O = !hold_valid && !CHANNEL_I;
        TX_BUSY_O  = (state != S_IDLE);
        TX_DONE_O  = final_tick && !CHANNEL_I;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I || CHANNEL_I) begin
            hold       <= '0;
            hold_esc   <= 1'b0;
            hold_valid <= 1'b0;
            pausing    <= 1'b0;
            last_esc   <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            tx_reg     <= 1'b1;
        end else begin
            tx_reg <= tx_nxt;
            // Residue carries across back-to-back frames so the rate never drifts.
            if (state == S_IDLE) acc <= '0;
            else if (tick)       acc <= acc_sum - CLK_MAX;
            else                 acc <= acc_sum;

            if (load)      cnt <= '0;
            else if (tick) cnt <= (state_nxt != state) ? 4'd0 : cnt + 4'd1;

            if (load) begin
                shreg   <= frame_byte;
                par_bit <= (PARITY == 1) ? ~^frame_byte : ^frame_byte;
            end else if (tick && state_nxt == S_DATA) begin
                shreg <= shreg >> 1;
            end

            if (load_data) begin
                hold_valid <= 1'b0;
                last_esc   <= hold_esc;
            end
            if (accept) begin
                hold       <= DATA_I;
                hold_esc   <= ESC_DETECTED_I;
                hold_valid <= 1'b1;
            end

            if (load_pt) begin
                if (pause_evt)       pausing <= 1'b1;
                else if (resume_evt) pausing <= 1'b0;
            end
        end
    end

endmodule
